// File: rtl/step_stats.sv
// step_stats: turns the pedometer step pulse train and the 1 Hz second tick
// into display statistics: total steps, distance in half-mile units, count of
// seconds 1..9 above OVER_RATE steps, and accumulated high-activity seconds.
// Latency: step outputs update on the edge that sees a step rising edge; the
// second-based outputs and sec_done update on the edge that sees a sec edge.
// Backpressure: none; all outputs are registered and always valid.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset, clears all state
//   start        run enable; low clears all state on the next clock edge
//   pulse_in     step pulse level; each rising edge is one step
//   sec_in       1 Hz level; each rising edge closes one second
//   step_count   total steps, saturating (9999 or 65535, see below)
//   distance     raw steps / STEPS_PER_HALF_MILE, truncated
//   over32_secs  seconds 1..9 with more than OVER_RATE steps
//   high_secs    accumulated high-activity seconds, saturating at 65535
//   sec_done     one-cycle strobe when the second-based outputs change
//
// Build option: define STEP_SAT_EN to saturate step_count at 9999 for a
// 4-digit display; otherwise it saturates at 65535.

module step_stats #(
    parameter int STEPS_PER_HALF_MILE = 1024,
    parameter int HIGH_RATE           = 64,
    parameter int HIGH_RUN            = 60,
    parameter int OVER_RATE           = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pulse_in,
    input  logic        sec_in,
    output logic [15:0] step_count,
    output logic [9:0]  distance,
    output logic [3:0]  over32_secs,
    output logic [15:0] high_secs,
    output logic        sec_done
);

`ifdef STEP_SAT_EN
    localparam logic [15:0] STEP_MAX = 16'd9999;
`else
    localparam logic [15:0] STEP_MAX = 16'd65535;
`endif

    localparam int             DIST_SH  = $clog2(STEPS_PER_HALF_MILE);
    localparam int             RUN_W    = $clog2(HIGH_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_END = RUN_W'(HIGH_RUN);
    localparam logic [7:0]     HIGH_TH  = 8'(HIGH_RATE);
    localparam logic [7:0]     OVER_TH  = 8'(OVER_RATE);
    localparam logic [16:0]    RUN_ADD  = 17'(HIGH_RUN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HIGH
    } state_t;

    state_t           r_state;
    logic             r_pulse_q;
    logic             r_sec_q;
    logic [19:0]      r_raw_steps;
    logic [15:0]      r_step_count;
    logic [7:0]       r_sec_steps;
    logic [8:0]       r_sec_idx;
    logic [3:0]       r_over32;
    logic [15:0]      r_high_secs;
    logic             r_sec_done;
    logic [RUN_W-1:0] r_run_len;

    logic             w_step_edge;
    logic             w_sec_edge;
    logic [7:0]       w_sec_eff;
    logic             w_hi;
    logic [16:0]      w_high_run_sum;
    logic [16:0]      w_high_one_sum;
    logic [15:0]      w_high_run_sat;
    logic [15:0]      w_high_one_sat;
    logic [19:0]      w_dist_full;

    assign w_step_edge = pulse_in & ~r_pulse_q;
    assign w_sec_edge  = sec_in & ~r_sec_q;

    // Steps in the closing second, counting a step that lands on the same
    // cycle as the second edge.
    assign w_sec_eff = (w_step_edge && (r_sec_steps != 8'hFF)) ?
                       (r_sec_steps + 8'd1) : r_sec_steps;
    assign w_hi      = (w_sec_eff >= HIGH_TH);

    assign w_high_run_sum = {1'b0, r_high_secs} + RUN_ADD;
    assign w_high_one_sum = {1'b0, r_high_secs} + 17'd1;
    assign w_high_run_sat = w_high_run_sum[16] ? 16'hFFFF : w_high_run_sum[15:0];
    assign w_high_one_sat = w_high_one_sum[16] ? 16'hFFFF : w_high_one_sum[15:0];

    assign w_dist_full = r_raw_steps >> DIST_SH;

    assign step_count  = r_step_count;
    assign distance    = w_dist_full[9:0];
    assign over32_secs = r_over32;
    assign high_secs   = r_high_secs;
    assign sec_done    = r_sec_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pulse_q    <= 1'b0;
            r_sec_q      <= 1'b0;
            r_raw_steps  <= '0;
            r_step_count <= '0;
            r_sec_steps  <= '0;
            r_sec_idx    <= '0;
            r_over32     <= '0;
            r_high_secs  <= '0;
            r_sec_done   <= 1'b0;
            r_run_len    <= '0;
        end else if (!start) begin
            r_state      <= S_IDLE;
            r_pulse_q    <= 1'b0;
            r_sec_q      <= 1'b0;
            r_raw_steps  <= '0;
            r_step_count <= '0;
            r_sec_steps  <= '0;
            r_sec_idx    <= '0;
            r_over32     <= '0;
            r_high_secs  <= '0;
            r_sec_done   <= 1'b0;
            r_run_len    <= '0;
        end else begin
            r_pulse_q  <= pulse_in;
            r_sec_q    <= sec_in;
            r_sec_done <= w_sec_edge;

            if (w_step_edge) begin
                if (r_raw_steps != 20'hFFFFF) begin
                    r_raw_steps <= r_raw_steps + 20'd1;
                end
                if (r_step_count != STEP_MAX) begin
                    r_step_count <= r_step_count + 16'd1;
                end
            end

            if (w_sec_edge) begin
                // The coincident step was folded into w_sec_eff, so the new
                // second starts from zero.
                r_sec_steps <= '0;
                if (r_sec_idx != 9'h1FF) begin
                    r_sec_idx <= r_sec_idx + 9'd1;
                end
                if ((r_sec_idx < 9'd9) && (w_sec_eff > OVER_TH)) begin
                    r_over32 <= r_over32 + 4'd1;
                end

                unique case (r_state)
                    S_IDLE: begin
                        if (w_hi) begin
                            r_state   <= S_RUN;
                            r_run_len <= RUN_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (w_hi) begin
                            if ((r_run_len + RUN_W'(1)) == RUN_END) begin
                                // A full run credits all of its seconds at once.
                                r_state     <= S_HIGH;
                                r_run_len   <= '0;
                                r_high_secs <= w_high_run_sat;
                            end else begin
                                r_run_len <= r_run_len + RUN_W'(1);
                            end
                        end else begin
                            r_state   <= S_IDLE;
                            r_run_len <= '0;
                        end
                    end
                    S_HIGH: begin
                        if (w_hi) begin
                            r_high_secs <= w_high_one_sat;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_run_len <= '0;
                    end
                endcase
            end else if (w_step_edge && (r_sec_steps != 8'hFF)) begin
                r_sec_steps <= r_sec_steps + 8'd1;
            end
        end
    end

endmodule
